// File: rtl/run_logger_pkg.sv
// rtl/run_logger_pkg.sv - shared defaults, tracker state and event types for run_logger
//
// Contents:
//   DEPTH_DEF, LEN_W_DEF  default FIFO depth and run-length field width
//   MAXLEN                largest run length representable at LEN_W_DEF
//   trk_state_t           tracker state (IDLE: no open run, RUN: run open)
//   run_event_t           one closed run {code, len} at the default width
package run_logger_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int LEN_W_DEF = 8;
    localparam int MAXLEN    = (1 << LEN_W_DEF) - 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } trk_state_t;

    typedef struct packed {
        logic [2:0]           code;
        logic [LEN_W_DEF-1:0] len;
    } run_event_t;

endpackage

// File: rtl/run_fifo.sv
// rtl/run_fifo.sv - first-word fall-through event FIFO with occupancy count
//
// Ports:
//   clk, clr            clock, asynchronous active-low reset
//   push, push_data     write strobe and data; dropped when full unless a pop happens too
//   pop                 read strobe; ignored when empty
//   pop_data            head entry, zero while empty
//   full, empty, count  status; count ranges 0..DEPTH
module run_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 11
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is forced to zero while empty so stale storage never shows on the outputs.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/run_logger.sv
// rtl/run_logger.sv - run-length logger: closes runs of equal codes into an event FIFO
//
// Optional feature macro: RUN_LOGGER_SPLIT_EN (split runs longer than MAXLEN
// instead of saturating the length).
//
// Ports:
//   clk, clr            clock, asynchronous active-low reset
//   in_code, in_valid   upstream code and its per-cycle qualifier
//   in_flush            close the open run; wins over a same-cycle sample
//   ev_valid, ev_ready  event handshake (pop on both high)
//   ev_code, ev_len     head event
//   ovf                 sticky: an event was dropped because the FIFO was full
//   cnt                 FIFO occupancy 0..DEPTH
module run_logger
    import run_logger_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [2:0]               in_code,
    input  logic                     in_valid,
    input  logic                     in_flush,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [2:0]               ev_code,
    output logic [LEN_W-1:0]         ev_len,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam logic [LEN_W-1:0] MAX_RUN = '1;
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    trk_state_t         state;
    trk_state_t         state_nx;
    logic [2:0]         cur_code;
    logic [2:0]         code_nx;
    logic [LEN_W-1:0]   run_len;
    logic [LEN_W-1:0]   len_nx;
    logic               push;
    logic               full;
    logic               empty;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            cur_code <= '0;
            run_len  <= '0;
        end else begin
            state    <= state_nx;
            cur_code <= code_nx;
            run_len  <= len_nx;
        end
    end

    // Every push closes the run currently held, so push data is always {cur_code, run_len}.
    always_comb begin
        state_nx = state;
        code_nx  = cur_code;
        len_nx   = run_len;
        push     = 1'b0;
        case (state)
            IDLE: begin
                if (!in_flush && in_valid) begin
                    state_nx = RUN;
                    code_nx  = in_code;
                    len_nx   = ONE;
                end
            end
            RUN: begin
                if (in_flush) begin
                    push     = 1'b1;
                    state_nx = IDLE;
                    len_nx   = '0;
                end else if (in_valid) begin
                    if (in_code != cur_code) begin
                        push    = 1'b1;
                        code_nx = in_code;
                        len_nx  = ONE;
                    end else if (run_len != MAX_RUN) begin
                        len_nx = run_len + ONE;
                    end else begin
`ifdef RUN_LOGGER_SPLIT_EN
                        push   = 1'b1;
                        len_nx = ONE;
`else
                        len_nx = MAX_RUN;
`endif
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    run_fifo #(
        .DEPTH (DEPTH),
        .W     (3 + LEN_W)
    ) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .push      (push),
        .push_data ({cur_code, run_len}),
        .pop       (ev_ready),
        .pop_data  ({ev_code, ev_len}),
        .full      (full),
        .empty     (empty),
        .count     (cnt)
    );

    assign ev_valid = !empty;

    // Full implies non-empty, so a same-cycle ev_ready always frees a slot.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ovf <= 1'b0;
        end else if (push && full && !ev_ready) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_run_logger.sv
// tb/tb_run_logger.sv - directed self-checking bench for run_logger
module tb_run_logger;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] in_code = '0;
    logic       in_valid = 1'b0;
    logic       in_flush = 1'b0;
    logic       ev_ready = 1'b0;
    logic       ev_valid;
    logic [2:0] ev_code;
    logic [7:0] ev_len;
    logic       ovf;
    logic [2:0] cnt;

    int checks = 0;
    int errors = 0;

    run_logger dut (
        .clk      (clk),
        .clr      (clr),
        .in_code  (in_code),
        .in_valid (in_valid),
        .in_flush (in_flush),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_code  (ev_code),
        .ev_len   (ev_len),
        .ovf      (ovf),
        .cnt      (cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_flush = 1'b0;
        ev_ready = 1'b0;
        in_code  = '0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        clr = 1'b0;
        tick();
        clr = 1'b1;
        tick();
    endtask

    task automatic sample(input logic [2:0] code);
        in_code  = code;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_code  = 3'($urandom_range(0, 7));
            in_valid = 1'($urandom_range(0, 1));
            in_flush = 1'($urandom_range(0, 1));
            ev_ready = 1'($urandom_range(0, 1));
            tick();
        end
        checks++;
        if (ev_valid !== 1'b0 || cnt !== 3'd0 || ovf !== 1'b0 || ev_code !== 3'd0 || ev_len !== 8'd0) begin
            errors++;
            $display("FAIL reset_hold: ev_valid=%b cnt=%0d ovf=%b code=%0d len=%0d, want 0 0 0 0 0",
                     ev_valid, cnt, ovf, ev_code, ev_len);
        end
        idle_inputs();
        clr = 1'b1;
        tick();
        checks++;
        if (ev_valid !== 1'b0 || cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: ev_valid=%b cnt=%0d, want 0 0", ev_valid, cnt);
        end
        // Build a queued event and an open run, then reset between edges.
        sample(3'd1);
        sample(3'd2);
        checks++;
        if (cnt !== 3'd1) begin
            errors++;
            $display("FAIL reset_prefill: cnt=%0d, want 1", cnt);
        end
        #2 clr = 1'b0;
        #1;
        checks++;
        if (ev_valid !== 1'b0 || cnt !== 3'd0 || ev_code !== 3'd0 || ev_len !== 8'd0) begin
            errors++;
            $display("FAIL reset_async: ev_valid=%b cnt=%0d code=%0d len=%0d, want 0 0 0 0",
                     ev_valid, cnt, ev_code, ev_len);
        end
        tick();
        clr = 1'b1;
        tick();
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        tick();
        checks++;
        if (cnt !== 3'd0 || ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard_run: cnt=%0d ev_valid=%b, want 0 0", cnt, ev_valid);
        end
    endtask

    task automatic test_basic_run();
        ev_ready = 1'b1;
        sample(3'd1);
        sample(3'd1);
        sample(3'd1);
        sample(3'd2);
        checks++;
        if (ev_valid !== 1'b1 || ev_code !== 3'd1 || ev_len !== 8'd3 || cnt !== 3'd1) begin
            errors++;
            $display("FAIL basic_event: valid=%b code=%0d len=%0d cnt=%0d, want 1 1 3 1",
                     ev_valid, ev_code, ev_len, cnt);
        end
        tick();
        checks++;
        if (ev_valid !== 1'b0 || cnt !== 3'd0) begin
            errors++;
            $display("FAIL basic_pop: valid=%b cnt=%0d, want 0 0", ev_valid, cnt);
        end
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        checks++;
        if (ev_valid !== 1'b1 || ev_code !== 3'd2 || ev_len !== 8'd1) begin
            errors++;
            $display("FAIL basic_flush: valid=%b code=%0d len=%0d, want 1 2 1", ev_valid, ev_code, ev_len);
        end
        tick();
        ev_ready = 1'b0;
        checks++;
        if (cnt !== 3'd0) begin
            errors++;
            $display("FAIL basic_drain: cnt=%0d, want 0", cnt);
        end
    endtask

    task automatic test_overflow();
        logic [2:0] exp_code [4];
        exp_code[0] = 3'd0; exp_code[1] = 3'd1; exp_code[2] = 3'd0; exp_code[3] = 3'd1;
        ev_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sample(3'(i % 2));
        end
        checks++;
        if (cnt !== 3'd4 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_state: cnt=%0d ovf=%b, want 4 1", cnt, ovf);
        end
        tick();
        tick();
        checks++;
        if (ev_code !== 3'd0 || ev_len !== 8'd1 || ev_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_head_stable: code=%0d len=%0d valid=%b, want 0 1 1", ev_code, ev_len, ev_valid);
        end
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ev_code !== exp_code[i] || ev_len !== 8'd1) begin
                errors++;
                $display("FAIL ovf_order[%0d]: code=%0d len=%0d, want %0d 1", i, ev_code, ev_len, exp_code[i]);
            end
            tick();
        end
        ev_ready = 1'b0;
        checks++;
        if (cnt !== 3'd0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: cnt=%0d ovf=%b, want 0 1", cnt, ovf);
        end
        pulse_reset();
        checks++;
        if (ovf !== 1'b0 || cnt !== 3'd0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b cnt=%0d, want 0 0", ovf, cnt);
        end
    endtask

    task automatic test_saturation();
        ev_ready = 1'b0;
        in_code  = 3'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 254) begin
                checks++;
                if (cnt !== 3'd0) begin
                    errors++;
                    $display("FAIL sat_no_early_push: cnt=%0d, want 0", cnt);
                end
            end
        end
        in_valid = 1'b0;
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
`ifdef RUN_LOGGER_SPLIT_EN
        checks++;
        if (cnt !== 3'd2 || ev_code !== 3'd3 || ev_len !== 8'd255) begin
            errors++;
            $display("FAIL split_first: cnt=%0d code=%0d len=%0d, want 2 3 255", cnt, ev_code, ev_len);
        end
        ev_ready = 1'b1;
        tick();
        checks++;
        if (ev_code !== 3'd3 || ev_len !== 8'd45) begin
            errors++;
            $display("FAIL split_second: code=%0d len=%0d, want 3 45", ev_code, ev_len);
        end
`else
        checks++;
        if (cnt !== 3'd1 || ev_code !== 3'd3 || ev_len !== 8'd255) begin
            errors++;
            $display("FAIL sat_event: cnt=%0d code=%0d len=%0d, want 1 3 255", cnt, ev_code, ev_len);
        end
        ev_ready = 1'b1;
`endif
        tick();
        ev_ready = 1'b0;
        checks++;
        if (cnt !== 3'd0) begin
            errors++;
            $display("FAIL sat_drain: cnt=%0d, want 0", cnt);
        end
    endtask

    task automatic test_flush_priority();
        ev_ready = 1'b0;
        sample(3'd2);
        tick();
        sample(3'd2);
        in_code  = 3'd5;
        in_valid = 1'b1;
        in_flush = 1'b1;
        tick();
        in_valid = 1'b0;
        in_flush = 1'b0;
        tick();
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        checks++;
        if (cnt !== 3'd1 || ev_code !== 3'd2 || ev_len !== 8'd2) begin
            errors++;
            $display("FAIL flush_priority: cnt=%0d code=%0d len=%0d, want 1 2 2", cnt, ev_code, ev_len);
        end
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        checks++;
        if (cnt !== 3'd0) begin
            errors++;
            $display("FAIL flush_drain: cnt=%0d, want 0", cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_code [4];
        exp_code[0] = 3'd5; exp_code[1] = 3'd4; exp_code[2] = 3'd5; exp_code[3] = 3'd4;
        ev_ready = 1'b0;
        sample(3'd4);
        sample(3'd4);
        sample(3'd5);
        sample(3'd4);
        sample(3'd5);
        sample(3'd4);
        checks++;
        if (cnt !== 3'd4 || ev_code !== 3'd4 || ev_len !== 8'd2) begin
            errors++;
            $display("FAIL b2b_full: cnt=%0d code=%0d len=%0d, want 4 4 2", cnt, ev_code, ev_len);
        end
        in_code  = 3'd6;
        in_valid = 1'b1;
        ev_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (cnt !== 3'd4 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_push_pop: cnt=%0d ovf=%b, want 4 0", cnt, ovf);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ev_code !== exp_code[i] || ev_len !== 8'd1) begin
                errors++;
                $display("FAIL b2b_order[%0d]: code=%0d len=%0d, want %0d 1", i, ev_code, ev_len, exp_code[i]);
            end
            tick();
        end
        checks++;
        if (cnt !== 3'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: cnt=%0d ovf=%b, want 0 0", cnt, ovf);
        end
        ev_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_overflow();
        test_saturation();
        test_flush_priority();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
